bbox_traverser: RTL

- Parametrised successor to the single-pixel bounding-box walker in the rasterizer front end.
- Accepts one pixel-space bounding box per triangle and clips it to the viewport and a programmable scissor rectangle.
- Walks the clipped box in LANES-wide, lane-aligned pixel groups, in raster or serpentine order.
- Feeds the triangle interpolator over a valid/ready stream, one group per cycle.

---
 rtl/bbox_traverser_pkg.sv | 44 ++++
 rtl/bbox_traverser_box_clipper.sv | 96 +++++++++
 rtl/bbox_traverser.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bbox_traverser_pkg.sv
// Shared types and helpers for the bounding-box traverser.
//   traversal_mode_t : walk order of a box (raster or serpentine)
//   pixel_box_t      : signed inclusive box corners (default width)
//   scissor_t        : unsigned inclusive scissor rectangle (default width)
//   sample_group_t   : one output beat (x, y, mask, last, id) at default widths,
//                      handy for software models of the default configuration
//   lane_hit()       : one bit of a group coverage mask
package bbox_traverser_pkg;

   localparam int MAX_LANES       = 16;
   localparam int DEF_COORD_WIDTH = 10;
   localparam int DEF_LANES       = 4;
   localparam int DEF_ID_WIDTH    = 4;

   typedef enum logic {RASTER = 1'b0, SERPENTINE = 1'b1} traversal_mode_t;

   typedef struct packed {
      logic signed [DEF_COORD_WIDTH:0] x0;
      logic signed [DEF_COORD_WIDTH:0] y0;
      logic signed [DEF_COORD_WIDTH:0] x1;
      logic signed [DEF_COORD_WIDTH:0] y1;
   } pixel_box_t;

   typedef struct packed {
      logic [DEF_COORD_WIDTH-1:0] x0;
      logic [DEF_COORD_WIDTH-1:0] y0;
      logic [DEF_COORD_WIDTH-1:0] x1;
      logic [DEF_COORD_WIDTH-1:0] y1;
   } scissor_t;

   typedef struct packed {
      logic [DEF_COORD_WIDTH-1:0] x;
      logic [DEF_COORD_WIDTH-1:0] y;
      logic [DEF_LANES-1:0]       mask;
      logic                       last;
      logic [DEF_ID_WIDTH-1:0]    id;
   } sample_group_t;

   // Pixel (base+lane) lies inside the inclusive span [lo, hi].
   function automatic logic lane_hit(input int lo, input int hi, input int base, input int lane);
      return (lane < MAX_LANES) && (base + lane >= lo) && (base + lane <= hi);
   endfunction

endpackage

// File: rtl/bbox_traverser_box_clipper.sv
// box_clipper: CLIP-stage registers of the traverser.
// Clamps the incoming box against the scissor and the viewport on the
// accepting handshake and registers the clipped span, the lane-aligned
// group range [gs, ge], the empty flag, walk mode and triangle tag.
//   clk, rst           : clock, async active-high reset
//   load               : box handshake strobe
//   box_*              : signed box corners, mode and tag
//   scissor_*          : inclusive scissor rectangle
//   cx0..cy1, gs, ge   : clipped span and aligned group range
//   empty, mode, id    : captured box attributes
module box_clipper
   import bbox_traverser_pkg::*;
#(
   parameter int VIEWPORT_WIDTH  = 64,
   parameter int VIEWPORT_HEIGHT = 64,
   parameter int COORD_WIDTH     = 10,
   parameter int LANES           = 4,
   parameter int ID_WIDTH        = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic signed [COORD_WIDTH:0]   box_x0,
   input  logic signed [COORD_WIDTH:0]   box_y0,
   input  logic signed [COORD_WIDTH:0]   box_x1,
   input  logic signed [COORD_WIDTH:0]   box_y1,
   input  logic                          box_serpentine,
   input  logic [ID_WIDTH-1:0]           box_id,
   input  logic [COORD_WIDTH-1:0]        scissor_x0,
   input  logic [COORD_WIDTH-1:0]        scissor_y0,
   input  logic [COORD_WIDTH-1:0]        scissor_x1,
   input  logic [COORD_WIDTH-1:0]        scissor_y1,
   output logic [COORD_WIDTH-1:0]        cx0,
   output logic [COORD_WIDTH-1:0]        cx1,
   output logic [COORD_WIDTH-1:0]        cy0,
   output logic [COORD_WIDTH-1:0]        cy1,
   output logic [COORD_WIDTH-1:0]        gs,
   output logic [COORD_WIDTH-1:0]        ge,
   output logic                          empty,
   output traversal_mode_t               mode,
   output logic [ID_WIDTH-1:0]           id
);

   // Two guard bits: one for the box sign, one so unsigned scissor values
   // and the viewport limits compare correctly against negative corners.
   localparam int SW = COORD_WIDTH + 2;
   typedef logic signed [SW-1:0] sc_t;

   localparam sc_t XMAX = sc_t'(VIEWPORT_WIDTH - 1);
   localparam sc_t YMAX = sc_t'(VIEWPORT_HEIGHT - 1);
   localparam logic [COORD_WIDTH-1:0] ALIGN = ~(COORD_WIDTH'(LANES - 1));

   function automatic sc_t smax(input sc_t a, input sc_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic sc_t smin(input sc_t a, input sc_t b);
      return (a < b) ? a : b;
   endfunction

   sc_t  nx0, nx1, ny0, ny1;
   logic nempty;

   assign nx0 = smax(smax(sc_t'(box_x0), sc_t'({2'b00, scissor_x0})), '0);
   assign nx1 = smin(smin(sc_t'(box_x1), sc_t'({2'b00, scissor_x1})), XMAX);
   assign ny0 = smax(smax(sc_t'(box_y0), sc_t'({2'b00, scissor_y0})), '0);
   assign ny1 = smin(smin(sc_t'(box_y1), sc_t'({2'b00, scissor_y1})), YMAX);
   assign nempty = (nx0 > nx1) || (ny0 > ny1);

   // Truncation is safe whenever the box is non-empty: the span then lies
   // inside the viewport. Empty boxes never use the span values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cx0   <= '0;
         cx1   <= '0;
         cy0   <= '0;
         cy1   <= '0;
         gs    <= '0;
         ge    <= '0;
         empty <= 1'b0;
         mode  <= RASTER;
         id    <= '0;
      end else if (load) begin
         cx0   <= nx0[COORD_WIDTH-1:0];
         cx1   <= nx1[COORD_WIDTH-1:0];
         cy0   <= ny0[COORD_WIDTH-1:0];
         cy1   <= ny1[COORD_WIDTH-1:0];
         gs    <= nx0[COORD_WIDTH-1:0] & ALIGN;
         ge    <= nx1[COORD_WIDTH-1:0] & ALIGN;
         empty <= nempty;
         mode  <= traversal_mode_t'(box_serpentine);
         id    <= box_id;
      end
   end

endmodule

// File: rtl/bbox_traverser.sv
// bbox_traverser: clips one bounding box per triangle to the viewport and
// scissor, then streams it as LANES-wide lane-aligned pixel groups in
// raster or serpentine order, one group per cycle.
//   clk, rst        : clock, async active-high reset
//   box_s_*         : box input stream (valid/ready), corners, mode, tag
//   scissor_*       : scissor rectangle, sampled at box acceptance
//   sample_m_*      : group output stream (valid/ready), x, y, mask, last, id
//   busy            : a box is being clipped or walked
module bbox_traverser
   import bbox_traverser_pkg::*;
#(
   parameter int VIEWPORT_WIDTH  = 64,
   parameter int VIEWPORT_HEIGHT = 64,
   parameter int COORD_WIDTH     = 10,
   parameter int LANES           = 4,
   parameter int ID_WIDTH        = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          box_s_ready,
   input  logic                          box_s_valid,
   input  logic signed [COORD_WIDTH:0]   box_s_x0,
   input  logic signed [COORD_WIDTH:0]   box_s_y0,
   input  logic signed [COORD_WIDTH:0]   box_s_x1,
   input  logic signed [COORD_WIDTH:0]   box_s_y1,
   input  logic                          box_s_serpentine,
   input  logic [ID_WIDTH-1:0]           box_s_id,
   input  logic [COORD_WIDTH-1:0]        scissor_x0,
   input  logic [COORD_WIDTH-1:0]        scissor_y0,
   input  logic [COORD_WIDTH-1:0]        scissor_x1,
   input  logic [COORD_WIDTH-1:0]        scissor_y1,
   input  logic                          sample_m_ready,
   output logic                          sample_m_valid,
   output logic [COORD_WIDTH-1:0]        sample_m_x,
   output logic [COORD_WIDTH-1:0]        sample_m_y,
   output logic [LANES-1:0]              sample_m_mask,
   output logic                          sample_m_last,
   output logic [ID_WIDTH-1:0]           sample_m_id,
   output logic                          busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CLIP = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [COORD_WIDTH-1:0] STEP = COORD_WIDTH'(LANES);

   logic [1:0]             state;
   logic                   odd_row;   // (y - cy0) is odd for the current beat

   logic [COORD_WIDTH-1:0] c_cx0, c_cx1, c_cy0, c_cy1, c_gs, c_ge;
   logic                   c_empty;
   traversal_mode_t        c_mode;
   logic [ID_WIDTH-1:0]    c_id;

   logic                   box_hs;

   assign box_s_ready = !rst && (state == S_IDLE);
   assign box_hs      = box_s_valid && box_s_ready;
   assign busy        = (state == S_CLIP) || (state == S_RUN);

   box_clipper #(
      .VIEWPORT_WIDTH (VIEWPORT_WIDTH),
      .VIEWPORT_HEIGHT(VIEWPORT_HEIGHT),
      .COORD_WIDTH    (COORD_WIDTH),
      .LANES          (LANES),
      .ID_WIDTH       (ID_WIDTH)
   ) u_clip (
      .clk           (clk),
      .rst           (rst),
      .load          (box_hs),
      .box_x0        (box_s_x0),
      .box_y0        (box_s_y0),
      .box_x1        (box_s_x1),
      .box_y1        (box_s_y1),
      .box_serpentine(box_s_serpentine),
      .box_id        (box_s_id),
      .scissor_x0    (scissor_x0),
      .scissor_y0    (scissor_y0),
      .scissor_x1    (scissor_x1),
      .scissor_y1    (scissor_y1),
      .cx0           (c_cx0),
      .cx1           (c_cx1),
      .cy0           (c_cy0),
      .cy1           (c_cy1),
      .gs            (c_gs),
      .ge            (c_ge),
      .empty         (c_empty),
      .mode          (c_mode),
      .id            (c_id)
   );

   // Next group position. In CLIP this is the first group of the box;
   // in RUN it steps from the group currently held in the output register.
   logic [COORD_WIDTH-1:0] nx, ny;
   logic                   nodd, fwd, nfwd, nlast;
   logic [LANES-1:0]       nmask;

   always_comb begin
      nx   = sample_m_x;
      ny   = sample_m_y;
      nodd = odd_row;
      fwd  = (c_mode == RASTER) || !odd_row;
      if (state == S_CLIP) begin
         nx   = c_gs;
         ny   = c_cy0;
         nodd = 1'b0;
      end else if (fwd && (sample_m_x != c_ge)) begin
         nx = sample_m_x + STEP;
      end else if (!fwd && (sample_m_x != c_gs)) begin
         nx = sample_m_x - STEP;
      end else begin
         // Row done: an odd next row in serpentine mode starts from ge.
         ny   = sample_m_y + 1'b1;
         nodd = !odd_row;
         nx   = ((c_mode == SERPENTINE) && !odd_row) ? c_ge : c_gs;
      end
      nfwd  = (c_mode == RASTER) || !nodd;
      nlast = (ny == c_cy1) && (nx == (nfwd ? c_ge : c_gs));
   end

   for (genvar i = 0; i < LANES; i++) begin : g_mask
      assign nmask[i] = lane_hit(int'(c_cx0), int'(c_cx1), int'(nx), i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         odd_row        <= 1'b0;
         sample_m_valid <= 1'b0;
         sample_m_x     <= '0;
         sample_m_y     <= '0;
         sample_m_mask  <= '0;
         sample_m_last  <= 1'b0;
         sample_m_id    <= '0;
      end else begin
         case (state)
            S_IDLE: if (box_hs) state <= S_CLIP;
            S_CLIP: begin
               state          <= S_RUN;
               sample_m_valid <= 1'b1;
               sample_m_id    <= c_id;
               if (c_empty) begin
                  // Single closing beat so downstream still retires the triangle.
                  sample_m_x    <= '0;
                  sample_m_y    <= '0;
                  sample_m_mask <= '0;
                  sample_m_last <= 1'b1;
                  odd_row       <= 1'b0;
               end else begin
                  sample_m_x    <= nx;
                  sample_m_y    <= ny;
                  sample_m_mask <= nmask;
                  sample_m_last <= nlast;
                  odd_row       <= nodd;
               end
            end
            S_RUN: if (sample_m_ready) begin
               if (sample_m_last) begin
                  sample_m_valid <= 1'b0;
                  state          <= S_IDLE;
               end else begin
                  sample_m_x    <= nx;
                  sample_m_y    <= ny;
                  sample_m_mask <= nmask;
                  sample_m_last <= nlast;
                  odd_row       <= nodd;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
